// File: rtl/mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mul_sched_pkg
// Description : Shared widths, pipeline/FIFO entry type and the approximate
//               12x12 product used by the shared-multiplier scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_sched_pkg;

  localparam int W_OP   = 12;
  localparam int W_PROD = 24;
  // Id field is sized for up to 16 requesters; the top uses the low bits.
  localparam int W_ID   = 4;

  typedef struct packed {
    logic [W_ID-1:0]   id;
    logic              approx;
    logic [W_PROD-1:0] prod;
  } entry_t;

  // Approximate product: only the two top partial-product bits survive.
  function automatic logic [W_PROD-1:0] approx_mul12(input logic [W_OP-1:0] a,
                                                     input logic [W_OP-1:0] b);
    logic [W_PROD-1:0] r;
    r     = '0;
    r[22] = a[11] & b[11];
    r[21] = a[11] & b[10];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mul_sched_fifo
// Description : Synchronous FIFO with register-held head data and registered
//               full/empty/count flags. Pointers wrap modulo DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_sched_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO accepts a push only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~r_empty;
  assign w_push = i_push & (~r_full | w_pop);

  // Storage array: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers, occupancy and flags; push+pop together leaves occupancy alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 1'b1;
          r_empty <= 1'b0;
          r_full  <= (r_count == CW'(DEPTH - 1));
        end
        2'b01: begin
          r_count <= r_count - 1'b1;
          r_full  <= 1'b0;
          r_empty <= (r_count == CW'(1));
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mul12u_share_sched.sv
`default_nettype none
// ============================================================================
// Module      : mul12u_share_sched
// Description : Shares one 12x12 unsigned multiplier among NREQ requesters.
//               Round-robin issue, LAT-stage result pipeline, in-order
//               response FIFO, credit-based flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module mul12u_share_sched
  import mul_sched_pkg::*;
#(
  parameter  int NREQ       = 4,
  parameter  int LAT        = 2,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDW        = $clog2(NREQ),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*W_OP-1:0] i_req_a,
  input  logic [NREQ*W_OP-1:0] i_req_b,
  input  logic [NREQ-1:0]      i_req_approx,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [W_PROD-1:0]    o_rsp_o,
  output logic                 o_rsp_approx
);

  localparam int SW = IDW + 1;

  logic [IDW-1:0]    r_ptr;
  logic [CW-1:0]     r_cnt;
  logic [LAT-1:0]    r_pipe_vld;
  entry_t            r_pipe [LAT];

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_gidx;
  logic [IDW-1:0]    w_scan;
  logic [SW-1:0]     w_sum;
  logic              w_found;
  logic              w_issue_ok;
  logic              w_accept;
  logic              w_pop;
  logic [W_OP-1:0]   w_a;
  logic [W_OP-1:0]   w_b;
  logic              w_ap;
  entry_t            w_new;
  entry_t            w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic              w_unused;

  // Round-robin search from r_ptr; issue only while a credit is free.
  always_comb begin
    w_grant    = '0;
    w_gidx     = '0;
    w_found    = 1'b0;
    w_sum      = '0;
    w_scan     = '0;
    w_issue_ok = ~rst & (r_cnt < CW'(FIFO_DEPTH));
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(NREQ)) w_sum = w_sum - SW'(NREQ);
      w_scan = w_sum[IDW-1:0];
      if (!w_found && i_req_valid[w_scan]) begin
        w_found = 1'b1;
        w_gidx  = w_scan;
      end
    end
    if (w_found && w_issue_ok) w_grant[w_gidx] = 1'b1;
  end

  assign o_req_ready = w_grant;
  assign w_accept    = |(i_req_valid & w_grant);

  // Winner's operands and the product computed in the accept cycle.
  always_comb begin
    w_a        = i_req_a[w_gidx*W_OP +: W_OP];
    w_b        = i_req_b[w_gidx*W_OP +: W_OP];
    w_ap       = i_req_approx[w_gidx];
    w_new      = '0;
    w_new.id   = W_ID'(w_gidx);
    w_new.approx = w_ap;
    w_new.prod = w_ap ? approx_mul12(w_a, w_b)
                      : W_PROD'(w_a) * W_PROD'(w_b);
  end

  // Pipeline valid bits: cleared on reset so nothing stale reaches the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      for (int s = 1; s < LAT; s++) r_pipe_vld[s] <= r_pipe_vld[s-1];
    end
  end

  // Pipeline payload: qualified by the valid bits, so no reset needed.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_new;
    for (int s = 1; s < LAT; s++) r_pipe[s] <= r_pipe[s-1];
  end

  assign w_pop = o_rsp_valid & i_rsp_ready;

  // Credit counter tracks in-flight plus queued results; RR pointer advances past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ptr <= '0;
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
      if (w_accept) begin
        r_ptr <= (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  mul_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pipe_vld[LAT-1]),
    .i_data  (r_pipe[LAT-1]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_rsp_valid  = ~rst & ~w_empty;
  assign o_rsp_id     = w_head.id[IDW-1:0];
  assign o_rsp_o      = w_head.prod;
  assign o_rsp_approx = w_head.approx;

  // FIFO status and spare id bits are not needed here; credits already bound occupancy.
  assign w_unused = &{1'b0, w_full, w_count, w_head.id};

endmodule
`default_nettype wire
